light_sel_sequencer: RTL and testbench

Generates the 6-bit light selector code that drives the light-manager decoder. Steps through codes `0 … STEPS-1`, holding each for a programmable dwell time. Supports one-shot or looping runs, pause and abort. It is the source end of the `sel` bus: each code it emits selects exactly one light pattern downstream.

---
 rtl/light_pkg.sv | 14 +
 rtl/light_dwell_timer.sv | 27 ++
 rtl/light_sel_sequencer.sv | 146 ++++++++++++++
 tb/tb_light_sel_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/light_pkg.sv
// Shared types and constants for the light selector sequencer.
package light_pkg;

    localparam int SEL_W = 6;

    localparam logic [SEL_W-1:0] SEL_IDLE_DEFAULT = 6'b111111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } light_seq_state_t;

endpackage

// File: rtl/light_dwell_timer.sv
// Loadable dwell down-counter; counts down to zero and stays there until reloaded.
module light_dwell_timer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_val,
    input  logic               hold,
    output logic               zero
);

    logic [DWELL_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (!hold && count != '0) begin
            count <= count - DWELL_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/light_sel_sequencer.sv
// Selector code sequencer: steps sel through 0..STEPS-1 with programmable dwell.
// Optional descending runs are enabled by defining LIGHT_SEQ_REVERSE_EN (adds port dir).
module light_sel_sequencer
    import light_pkg::*;
#(
    parameter int                 STEPS    = 10,
    parameter int                 DWELL_W  = 8,
    parameter logic [SEL_W-1:0]   IDLE_SEL = SEL_IDLE_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic               loop,
    input  logic [DWELL_W-1:0] dwell,
`ifdef LIGHT_SEQ_REVERSE_EN
    input  logic               dir,
`endif
    output logic [SEL_W-1:0]   sel,
    output logic               step_strobe,
    output logic               running,
    output logic               done
);

    localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

    light_seq_state_t   state;
    logic [STEP_W-1:0]  step;
    logic [DWELL_W-1:0] dwell_q;
    logic               loop_q;

    logic [STEP_W-1:0]  first_in;
    logic [STEP_W-1:0]  first_q;
    logic [STEP_W-1:0]  last_q;
    logic [STEP_W-1:0]  next_step;

`ifdef LIGHT_SEQ_REVERSE_EN
    logic dir_q;

    always_comb begin
        first_in  = dir   ? LAST_STEP : '0;
        first_q   = dir_q ? LAST_STEP : '0;
        last_q    = dir_q ? '0 : LAST_STEP;
        next_step = dir_q ? step - STEP_W'(1) : step + STEP_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dir_q <= 1'b0;
        end else if (start && !stop) begin
            dir_q <= dir;
        end
    end
`else
    always_comb begin
        first_in  = '0;
        first_q   = '0;
        last_q    = LAST_STEP;
        next_step = step + STEP_W'(1);
    end
`endif

    // A PAUSE cycle with pause low already counts, so resuming costs no extra cycle.
    logic go;
    logic active;
    logic zero;
    logic tmr_load;
    logic tmr_hold;

    always_comb begin
        go       = start && !stop;
        active   = (state != IDLE) && !pause && !stop && !start;
        tmr_load = go || (active && zero);
        tmr_hold = !(go || active);
    end

    light_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (go ? dwell : dwell_q),
        .hold     (tmr_hold),
        .zero     (zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sel         <= IDLE_SEL;
            step_strobe <= 1'b0;
            running     <= 1'b0;
            done        <= 1'b0;
            step        <= '0;
            dwell_q     <= '0;
            loop_q      <= 1'b0;
        end else begin
            step_strobe <= 1'b0;
            done        <= 1'b0;
            if (stop) begin
                state   <= IDLE;
                sel     <= IDLE_SEL;
                running <= 1'b0;
            end else if (start) begin
                state       <= RUN;
                step        <= first_in;
                sel         <= SEL_W'(first_in);
                step_strobe <= 1'b1;
                running     <= 1'b1;
                dwell_q     <= dwell;
                loop_q      <= loop;
            end else begin
                case (state)
                    RUN, PAUSE: begin
                        if (pause) begin
                            state <= PAUSE;
                        end else begin
                            state <= RUN;
                            if (zero) begin
                                if (step != last_q) begin
                                    step        <= next_step;
                                    sel         <= SEL_W'(next_step);
                                    step_strobe <= 1'b1;
                                end else if (loop_q) begin
                                    step        <= first_q;
                                    sel         <= SEL_W'(first_q);
                                    step_strobe <= 1'b1;
                                end else begin
                                    state   <= IDLE;
                                    sel     <= IDLE_SEL;
                                    running <= 1'b0;
                                    done    <= 1'b1;
                                end
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_light_sel_sequencer.sv
// Directed self-checking bench for light_sel_sequencer (STEPS=10).
module tb_light_sel_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       pause = 1'b0;
    logic       loop = 1'b0;
    logic [7:0] dwell = '0;
`ifdef LIGHT_SEQ_REVERSE_EN
    logic       dir = 1'b0;
`endif
    logic [5:0] sel;
    logic       step_strobe;
    logic       running;
    logic       done;

    int total = 0;
    int bad = 0;
    int strobes;

    always #5 clk = ~clk;

    light_sel_sequencer #(
        .STEPS    (10),
        .DWELL_W  (8),
        .IDLE_SEL (6'b111111)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .pause       (pause),
        .loop        (loop),
        .dwell       (dwell),
`ifdef LIGHT_SEQ_REVERSE_EN
        .dir         (dir),
`endif
        .sel         (sel),
        .step_strobe (step_strobe),
        .running     (running),
        .done        (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_sel"}, 32'(sel), 32'h3f);
        check({tag, "_run"}, 32'(running), 0);
        check({tag, "_strb"}, 32'(step_strobe), 0);
    endtask

    initial begin
        // reset
        rst = 1'b1;
        tick();
        tick();
        check_idle("reset");
        check("reset_done", 32'(done), 0);
        rst = 1'b0;
        tick();

        // one-shot, dwell=2
        dwell = 8'd2; loop = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        strobes = 0;
        for (int c = 1; c <= 31; c++) begin
            if (step_strobe) strobes++;
            if (c <= 30) begin
                check($sformatf("os_sel_c%0d", c), 32'(sel), 32'((c - 1) / 3));
                check($sformatf("os_strb_c%0d", c), 32'(step_strobe), 32'(((c - 1) % 3) == 0));
                check($sformatf("os_done_c%0d", c), 32'(done), 0);
                check($sformatf("os_run_c%0d", c), 32'(running), 1);
            end else begin
                check("os_end_sel", 32'(sel), 32'h3f);
                check("os_end_done", 32'(done), 1);
                check("os_end_run", 32'(running), 0);
            end
            tick();
        end
        check("os_strobes", 32'(strobes), 10);
        check("os_done_pulse", 32'(done), 0);

        // looping, dwell=0
        dwell = 8'd0; loop = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            check($sformatf("lp_sel_c%0d", c), 32'(sel), 32'((c - 1) % 10));
            check($sformatf("lp_strb_c%0d", c), 32'(step_strobe), 1);
            check($sformatf("lp_done_c%0d", c), 32'(done), 0);
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_idle("lp_stop");

        // pause during second cycle of code 4, dwell=3
        dwell = 8'd3; loop = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 29; c++) begin
            int exp_sel;
            pause = (c >= 18 && c <= 22);
            if (c < 17)       exp_sel = (c - 1) / 4;
            else if (c <= 25) exp_sel = 4;
            else              exp_sel = 5;
            check($sformatf("ps_sel_c%0d", c), 32'(sel), 32'(exp_sel));
            check($sformatf("ps_run_c%0d", c), 32'(running), 1);
            tick();
        end
        pause = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_idle("ps_stop");
        check("ps_stop_done", 32'(done), 0);

        // stop and start together in idle
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check_idle("ss_idle");
        tick();
        check_idle("ss_idle2");

        // stop mid-run at code 6
        dwell = 8'd0; loop = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 7; c++) tick();
        check("st_code6", 32'(sel), 6);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_idle("st_stop");
        check("st_done", 32'(done), 0);
        for (int c = 0; c < 6; c++) begin
            tick();
            check($sformatf("st_nodone_%0d", c), 32'(done), 0);
        end

        // start with pause in idle, then restart mid-run
        dwell = 8'd0; loop = 1'b1; start = 1'b1; pause = 1'b1;
        tick();
        start = 1'b0;
        check("sp_sel", 32'(sel), 0);
        check("sp_strb", 32'(step_strobe), 1);
        check("sp_run", 32'(running), 1);
        tick();
        check("sp_hold_sel", 32'(sel), 0);
        check("sp_hold_strb", 32'(step_strobe), 0);
        tick();
        check("sp_hold_sel2", 32'(sel), 0);
        check("sp_hold_run", 32'(running), 1);
        pause = 1'b0;
        tick();
        check("sp_resume_sel", 32'(sel), 1);
        tick();
        tick();
        check("rs_pre_sel", 32'(sel), 3);
        start = 1'b1; pause = 1'b1;
        tick();
        start = 1'b0; pause = 1'b0;
        check("rs_sel", 32'(sel), 0);
        check("rs_strb", 32'(step_strobe), 1);
        tick();
        check("rs_next_sel", 32'(sel), 1);

        // reset mid-run
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("rr");
        check("rr_done", 32'(done), 0);
        tick();
        check("rr_done2", 32'(done), 0);

`ifdef LIGHT_SEQ_REVERSE_EN
        // descending one-shot
        dwell = 8'd0; loop = 1'b0; dir = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            check($sformatf("rv_sel_c%0d", c), 32'(sel), 32'(10 - c));
            check($sformatf("rv_done_c%0d", c), 32'(done), 0);
            tick();
        end
        check("rv_end_sel", 32'(sel), 32'h3f);
        check("rv_end_done", 32'(done), 1);
        dir = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
